mano_datapath_p: RTL and testbench
==================================

# mano_datapath_p

Parametrised successor of the basic-computer datapath. Holds AR, PC, DR, AC, IR, TR, E, IEN, INPR and OUTR, the common bus, and an 8-op ALU. It adds FGI/FGO valid-ready I/O handshakes and an interrupt request. Main memory is external and combinationally read; the control unit drives all select, load, increment and clear strobes.

## Interface
- DW, 16, data/bus width (≥ IOW+1)
- AW, 12, address width (AR, PC; < DW)
- IOW, 8, INPR/OUTR width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- bus_sel  in  3  0:zero 1:AR 2:PC 3:DR 4:AC 5:IR 6:TR 7:mem_rdata (AR/PC zero-extended)
- alu_sel  in  3  ALU op (see Operation)
- reg_ld / reg_inc / reg_clr  in  6 each  per-register strobes; bit0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR
- e_clr, e_cmp  in  1 each  clear / complement E
- ien_set, ien_clr  in  1 each  IEN control
- outr_ld  in  1  OUTR ← AC[IOW-1:0]
- mem_write  in  1  write bus to memory
- mem_addr  out  AW  = AR
- mem_wdata  out  DW  = bus
- mem_we  out  1  = mem_write
- mem_rdata  in  DW  memory read data for AR
- in_data  in  IOW; in_valid  in  1; in_ready  out  1  input handshake
- out_data  out  IOW; out_valid  out  1; out_ready  in  1  output handshake
- bus  out  DW; ar, pc  out  AW; dr, ac, ir  out  DW; e, ien, fgi, fgo, irq  out  1

## Operation
- AR, PC, DR, IR, TR load from the bus (AR/PC take bus[AW-1:0]). AC loads from the ALU result.
- Per-register priority: clr > ld > inc. inc wraps modulo 2^width.
- ALU ops, applied when reg_ld[3]:
  - 0: AC&DR
  - 1: AC+DR, E ← carry
  - 2: DR
  - 3: ~AC
  - 4: CIR: AC ← {E,AC[DW-1:1]}, E ← AC[0]
  - 5: CIL: AC ← {AC[DW-2:0],E}, E ← AC[DW-1]
  - 6: INP: AC ← {AC[DW-1:IOW],INPR}, FGI ← 0
  - 7: AC
- E priority: e_clr > e_cmp > ALU update (ops 1, 4, 5 with reg_ld[3]).
- Input channel:
  - in_ready = ~FGI.
  - When in_valid & in_ready, INPR ← in_data and FGI ← 1.
  - If INP and an input capture occur in the same cycle: AC takes the old INPR, and FGI ends at 1 (capture wins).
- Output channel:
  - out_valid = ~FGO; out_data = OUTR.
  - outr_ld: OUTR ← AC[IOW-1:0], FGO ← 0.
  - When out_valid & out_ready, FGO ← 1.
  - outr_ld in the same cycle as the consume: outr_ld wins (FGO = 0, new data).
- IEN: ien_clr > ien_set. irq = IEN & (FGI | FGO).
- Reset values: all registers, E, IEN, FGI, INPR, OUTR = 0; FGO = 1. Resulting outputs: in_ready = 1, out_valid = 0, irq = 0.

## Timing
- Bus, mem_*, in_ready, out_valid, irq are combinational from state and inputs.
- All state updates occur on the rising edge of clk. Reset clears state immediately, independent of clk; deassertion is synchronous to the next edge.
- Register-to-register transfer over the bus: 1 cycle. Input capture to fgi=1: 1 cycle.
- Reset mid-transfer discards the pending update and any held data. No handshake completes in a cycle where reset is high.

## Configuration
- MANO_DP_INT_EN defined: IEN register and irq are implemented as above.
- MANO_DP_INT_EN undefined: IEN and irq are constant 0; ien_set and ien_clr are ignored. FGI/FGO handshakes are unchanged.

## Test plan
- Reset during load: assert reset mid-cycle with PC=0x123 → pc=0, ac=0, fgo=1, out_valid=0, in_ready=1 with no clock edge.
- ADD carry: AC=0xFFFF, DR=0x0001, alu_sel=1, reg_ld[3] → AC=0x0000, E=1. Then CIL → AC=0x0001, E=0.
- Priority: reg_clr[1], reg_ld[1], reg_inc[1] together with bus=0x0ABC → PC=0. Then inc at PC=0xFFF → PC=0x000.
- Input: in_data=0x5A, in_valid held high 3 cycles → INPR=0x5A, fgi=1, in_ready=0, second byte not taken. INP with AC=0x1200 → AC=0x125A, fgi=0.
- Output: AC=0x00C3, outr_ld → out_data=0xC3, out_valid=1. out_ready held low 2 cycles, then high → fgo=1 one cycle later.
- Interrupt (MANO_DP_INT_EN defined): ien_set with fgo=1 → irq=1. Same stimulus without the macro → irq=0, ien=0.

Source files
------------

// File: rtl/mano_datapath_p.sv
// Basic-computer datapath: common bus, register file, 8-op ALU, FGI/FGO valid-ready I/O.
// Define MANO_DP_INT_EN to implement IEN and irq; otherwise both are constant 0.
module mano_datapath_p #(
    parameter int DW  = 16,
    parameter int AW  = 12,
    parameter int IOW = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2:0]     bus_sel,
    input  logic [2:0]     alu_sel,
    input  logic [5:0]     reg_ld,
    input  logic [5:0]     reg_inc,
    input  logic [5:0]     reg_clr,
    input  logic           e_clr,
    input  logic           e_cmp,
    input  logic           ien_set,
    input  logic           ien_clr,
    input  logic           outr_ld,
    input  logic           mem_write,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    output logic           mem_we,
    input  logic [DW-1:0]  mem_rdata,
    input  logic [IOW-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [IOW-1:0] out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  bus,
    output logic [AW-1:0]  ar,
    output logic [AW-1:0]  pc,
    output logic [DW-1:0]  dr,
    output logic [DW-1:0]  ac,
    output logic [DW-1:0]  ir,
    output logic           e,
    output logic           ien,
    output logic           fgi,
    output logic           fgo,
    output logic           irq
);

    logic [DW-1:0]  tr;
    logic [IOW-1:0] inpr;
    logic [IOW-1:0] outr;
    logic [DW-1:0]  alu_res;
    logic           alu_c;
    logic           alu_e_upd;
    logic           in_fire;
    logic           out_fire;
    logic           inp_op;

    always_comb begin
        case (bus_sel)
            3'd0:    bus = '0;
            3'd1:    bus = {{(DW-AW){1'b0}}, ar};
            3'd2:    bus = {{(DW-AW){1'b0}}, pc};
            3'd3:    bus = dr;
            3'd4:    bus = ac;
            3'd5:    bus = ir;
            3'd6:    bus = tr;
            default: bus = mem_rdata;
        endcase
    end

    always_comb begin
        alu_res   = ac;
        alu_c     = e;
        alu_e_upd = 1'b0;
        case (alu_sel)
            3'd0: alu_res = ac & dr;
            3'd1: begin
                {alu_c, alu_res} = {1'b0, ac} + {1'b0, dr};
                alu_e_upd = 1'b1;
            end
            3'd2: alu_res = dr;
            3'd3: alu_res = ~ac;
            3'd4: begin
                alu_res   = {e, ac[DW-1:1]};
                alu_c     = ac[0];
                alu_e_upd = 1'b1;
            end
            3'd5: begin
                alu_res   = {ac[DW-2:0], e};
                alu_c     = ac[DW-1];
                alu_e_upd = 1'b1;
            end
            3'd6:    alu_res = {ac[DW-1:IOW], inpr};
            default: alu_res = ac;
        endcase
    end

    assign mem_addr  = ar;
    assign mem_wdata = bus;
    assign mem_we    = mem_write;
    assign in_ready  = ~fgi;
    assign out_valid = ~fgo;
    assign out_data  = outr;
    assign in_fire   = in_valid & ~fgi;
    assign out_fire  = out_ready & ~fgo;
    assign inp_op    = reg_ld[3] && (alu_sel == 3'd6);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar   <= '0;
            pc   <= '0;
            dr   <= '0;
            ac   <= '0;
            ir   <= '0;
            tr   <= '0;
            e    <= 1'b0;
            fgi  <= 1'b0;
            fgo  <= 1'b1;
            inpr <= '0;
            outr <= '0;
        end else begin
            if (reg_clr[0])      ar <= '0;
            else if (reg_ld[0])  ar <= bus[AW-1:0];
            else if (reg_inc[0]) ar <= ar + AW'(1);

            if (reg_clr[1])      pc <= '0;
            else if (reg_ld[1])  pc <= bus[AW-1:0];
            else if (reg_inc[1]) pc <= pc + AW'(1);

            if (reg_clr[2])      dr <= '0;
            else if (reg_ld[2])  dr <= bus;
            else if (reg_inc[2]) dr <= dr + DW'(1);

            if (reg_clr[3])      ac <= '0;
            else if (reg_ld[3])  ac <= alu_res;
            else if (reg_inc[3]) ac <= ac + DW'(1);

            if (reg_clr[4])      ir <= '0;
            else if (reg_ld[4])  ir <= bus;
            else if (reg_inc[4]) ir <= ir + DW'(1);

            if (reg_clr[5])      tr <= '0;
            else if (reg_ld[5])  tr <= bus;
            else if (reg_inc[5]) tr <= tr + DW'(1);

            if (e_clr)                       e <= 1'b0;
            else if (e_cmp)                  e <= ~e;
            else if (reg_ld[3] && alu_e_upd) e <= alu_c;

            // A capture in the same cycle as INP leaves FGI set; AC still gets the old INPR.
            if (in_fire) begin
                inpr <= in_data;
                fgi  <= 1'b1;
            end else if (inp_op) begin
                fgi  <= 1'b0;
            end

            if (outr_ld) begin
                outr <= ac[IOW-1:0];
                fgo  <= 1'b0;
            end else if (out_fire) begin
                fgo  <= 1'b1;
            end
        end
    end

`ifdef MANO_DP_INT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ien <= 1'b0;
        else if (ien_clr) ien <= 1'b0;
        else if (ien_set) ien <= 1'b1;
    end

    assign irq = ien & (fgi | fgo);
`else
    logic unused_ien;
    assign unused_ien = ien_set ^ ien_clr;
    assign ien        = 1'b0;
    assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_mano_datapath_p.sv
// Directed bench for mano_datapath_p with an arithmetic reference model checked every cycle.
module tb_mano_datapath_p;

    localparam int DW  = 16;
    localparam int AW  = 12;
    localparam int IOW = 8;

    logic           clk;
    logic           reset;
    logic [2:0]     bus_sel;
    logic [2:0]     alu_sel;
    logic [5:0]     reg_ld;
    logic [5:0]     reg_inc;
    logic [5:0]     reg_clr;
    logic           e_clr;
    logic           e_cmp;
    logic           ien_set;
    logic           ien_clr;
    logic           outr_ld;
    logic           mem_write;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           mem_we;
    logic [DW-1:0]  mem_rdata;
    logic [IOW-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic [IOW-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  bus;
    logic [AW-1:0]  ar;
    logic [AW-1:0]  pc;
    logic [DW-1:0]  dr;
    logic [DW-1:0]  ac;
    logic [DW-1:0]  ir;
    logic           e;
    logic           ien;
    logic           fgi;
    logic           fgo;
    logic           irq;

    int n_checks = 0;
    int n_errors = 0;

    mano_datapath_p #(.DW(DW), .AW(AW), .IOW(IOW)) dut (
        .clk(clk), .reset(reset), .bus_sel(bus_sel), .alu_sel(alu_sel),
        .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_clr(reg_clr),
        .e_clr(e_clr), .e_cmp(e_cmp), .ien_set(ien_set), .ien_clr(ien_clr),
        .outr_ld(outr_ld), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .bus(bus), .ar(ar), .pc(pc), .dr(dr), .ac(ac), .ir(ir),
        .e(e), .ien(ien), .fgi(fgi), .fgo(fgo), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers, arithmetic wrap by modulus.
    int unsigned m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_inpr, m_outr;
    bit          m_e, m_ien, m_fgi, m_fgo;

    function automatic int unsigned m_bus();
        case (bus_sel)
            3'd1:    return m_ar;
            3'd2:    return m_pc;
            3'd3:    return m_dr;
            3'd4:    return m_ac;
            3'd5:    return m_ir;
            3'd6:    return m_tr;
            3'd7:    return 32'(mem_rdata);
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned nxt(int unsigned old, logic c, logic l,
                                        int unsigned v, logic i, int unsigned md);
        if (c) return 0;
        if (l) return v % md;
        if (i) return (old + 1) % md;
        return old;
    endfunction

    always @(posedge clk or posedge reset) begin
        int unsigned a, t, r;
        bit ce, eu, inp, cap, cons;
        if (reset) begin
            m_ar <= 0; m_pc <= 0; m_dr <= 0; m_ac <= 0; m_ir <= 0; m_tr <= 0;
            m_inpr <= 0; m_outr <= 0; m_e <= 0; m_ien <= 0; m_fgi <= 0; m_fgo <= 1;
        end else begin
            a = m_bus();
            r = m_ac; ce = 0; eu = 0; t = 0;
            case (alu_sel)
                3'd0: r = m_ac & m_dr;
                3'd1: begin t = m_ac + m_dr; r = t % 65536; ce = (t >= 65536); eu = 1; end
                3'd2: r = m_dr;
                3'd3: r = 65535 - m_ac;
                3'd4: begin r = m_ac / 2 + (m_e ? 32768 : 0); ce = (m_ac % 2 == 1); eu = 1; end
                3'd5: begin r = (m_ac * 2) % 65536 + (m_e ? 1 : 0); ce = (m_ac >= 32768); eu = 1; end
                3'd6: r = (m_ac / 256) * 256 + m_inpr;
                default: r = m_ac;
            endcase
            inp  = reg_ld[3] && (alu_sel == 3'd6);
            cap  = in_valid && !m_fgi;
            cons = out_ready && !m_fgo;
            m_ar <= nxt(m_ar, reg_clr[0], reg_ld[0], a, reg_inc[0], 4096);
            m_pc <= nxt(m_pc, reg_clr[1], reg_ld[1], a, reg_inc[1], 4096);
            m_dr <= nxt(m_dr, reg_clr[2], reg_ld[2], a, reg_inc[2], 65536);
            m_ac <= nxt(m_ac, reg_clr[3], reg_ld[3], r, reg_inc[3], 65536);
            m_ir <= nxt(m_ir, reg_clr[4], reg_ld[4], a, reg_inc[4], 65536);
            m_tr <= nxt(m_tr, reg_clr[5], reg_ld[5], a, reg_inc[5], 65536);
            m_e  <= e_clr ? 1'b0 : e_cmp ? !m_e : (reg_ld[3] && eu) ? ce : m_e;
            if (cap) m_inpr <= 32'(in_data);
            m_fgi <= cap ? 1'b1 : inp ? 1'b0 : m_fgi;
            if (outr_ld) m_outr <= m_ac % 256;
            m_fgo <= outr_ld ? 1'b0 : cons ? 1'b1 : m_fgo;
`ifdef MANO_DP_INT_EN
            m_ien <= ien_clr ? 1'b0 : ien_set ? 1'b1 : m_ien;
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #3;
        if (!reset) begin
            chk("bus",       32'(bus),       m_bus());
            chk("mem_addr",  32'(mem_addr),  m_ar);
            chk("mem_wdata", 32'(mem_wdata), m_bus());
            chk("mem_we",    32'(mem_we),    32'(mem_write));
            chk("ar",        32'(ar),        m_ar);
            chk("pc",        32'(pc),        m_pc);
            chk("dr",        32'(dr),        m_dr);
            chk("ac",        32'(ac),        m_ac);
            chk("ir",        32'(ir),        m_ir);
            chk("e",         32'(e),         32'(m_e));
            chk("ien",       32'(ien),       32'(m_ien));
            chk("fgi",       32'(fgi),       32'(m_fgi));
            chk("fgo",       32'(fgo),       32'(m_fgo));
            chk("irq",       32'(irq),       32'(m_ien && (m_fgi || m_fgo)));
            chk("in_ready",  32'(in_ready),  32'(!m_fgi));
            chk("out_valid", 32'(out_valid), 32'(!m_fgo));
            chk("out_data",  32'(out_data),  m_outr);
        end
    end

    task automatic step();
        @(posedge clk);
        #6;
        reg_ld = '0; reg_inc = '0; reg_clr = '0;
        e_clr = 1'b0; e_cmp = 1'b0; ien_set = 1'b0; ien_clr = 1'b0;
        outr_ld = 1'b0; mem_write = 1'b0;
    endtask

    task automatic load_dr(input logic [15:0] v);
        bus_sel = 3'd7; mem_rdata = v; reg_ld = 6'b000100;
        step();
    endtask

    task automatic set_ac(input logic [15:0] v);
        load_dr(v);
        alu_sel = 3'd2; reg_ld = 6'b001000;
        step();
    endtask

    task automatic alu_op(input logic [2:0] op);
        alu_sel = op; reg_ld = 6'b001000;
        step();
    endtask

    initial begin
        reset = 1'b1;
        bus_sel = '0; alu_sel = '0; reg_ld = '0; reg_inc = '0; reg_clr = '0;
        e_clr = 0; e_cmp = 0; ien_set = 0; ien_clr = 0; outr_ld = 0; mem_write = 0;
        mem_rdata = '0; in_data = '0; in_valid = 0; out_ready = 0;
        #1;
        chk("rst_pc",        32'(pc),        32'h0);
        chk("rst_fgo",       32'(fgo),       32'h1);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_irq",       32'(irq),       32'h0);
        #2 reset = 1'b0;

        // Build up state, then reset asynchronously in mid-cycle.
        bus_sel = 3'd7; mem_rdata = 16'h0123; reg_ld = 6'b000010;
        step();
        chk("pc_load", 32'(pc), 32'h123);
        set_ac(16'h00C3);
        outr_ld = 1'b1; step();
        in_valid = 1'b1; in_data = 8'h11; step();
        in_valid = 1'b0;
        chk("pre_rst_fgi", 32'(fgi), 32'h1);
        reset = 1'b1;
        #1;
        chk("async_pc",        32'(pc),        32'h0);
        chk("async_ac",        32'(ac),        32'h0);
        chk("async_fgo",       32'(fgo),       32'h1);
        chk("async_out_valid", 32'(out_valid), 32'h0);
        chk("async_in_ready",  32'(in_ready),  32'h1);
        bus_sel = 3'd7; mem_rdata = 16'h0ABC; reg_ld = 6'b000010;
        in_valid = 1'b1; in_data = 8'h22;
        step();
        chk("rst_hold_pc",  32'(pc),  32'h0);
        chk("rst_hold_fgi", 32'(fgi), 32'h0);
        reset = 1'b0; in_valid = 1'b0;

        // ADD with carry, then rotates and E complement.
        set_ac(16'hFFFF);
        load_dr(16'h0001);
        alu_op(3'd1);
        chk("add_ac", 32'(ac), 32'h0000);
        chk("add_e",  32'(e),  32'h1);
        alu_op(3'd5);
        chk("cil_ac", 32'(ac), 32'h0001);
        chk("cil_e",  32'(e),  32'h0);
        alu_op(3'd4);
        chk("cir_ac", 32'(ac), 32'h0000);
        chk("cir_e",  32'(e),  32'h1);
        e_cmp = 1'b1; step();
        chk("ecmp_e", 32'(e), 32'h0);
        e_cmp = 1'b1; e_clr = 1'b1; step();
        chk("eclr_wins", 32'(e), 32'h0);

        set_ac(16'h0F0F);
        load_dr(16'h00FF);
        alu_op(3'd0);
        chk("and_ac", 32'(ac), 32'h000F);
        alu_op(3'd3);
        chk("not_ac", 32'(ac), 32'hFFF0);

        // Strobe priority and PC wrap.
        bus_sel = 3'd7; mem_rdata = 16'h0ABC;
        reg_clr = 6'b000010; reg_ld = 6'b000010; reg_inc = 6'b000010;
        step();
        chk("prio_pc", 32'(pc), 32'h000);
        mem_rdata = 16'h0FFF; reg_ld = 6'b000010; step();
        chk("pc_fff", 32'(pc), 32'hFFF);
        reg_inc = 6'b000010; step();
        chk("pc_wrap", 32'(pc), 32'h000);

        // AR/IR/TR from memory, TR onto the bus with a memory write.
        mem_rdata = 16'hBEEF; reg_ld = 6'b110001; step();
        chk("ar_trunc", 32'(ar), 32'hEEF);
        chk("ir_load",  32'(ir), 32'hBEEF);
        bus_sel = 3'd6; mem_write = 1'b1; step();
        chk("bus_tr", 32'(bus), 32'hBEEF);
        reg_inc = 6'b000001; step();
        chk("ar_inc", 32'(ar), 32'hEF0);

        // Input channel.
        set_ac(16'h1200);
        in_valid = 1'b1; in_data = 8'h5A; step();
        chk("in_fgi",   32'(fgi),      32'h1);
        chk("in_ready", 32'(in_ready), 32'h0);
        in_data = 8'h77; step(); step();
        in_valid = 1'b0;
        alu_op(3'd6);
        chk("inp_ac",  32'(ac),  32'h125A);
        chk("inp_fgi", 32'(fgi), 32'h0);
        in_valid = 1'b1; in_data = 8'h3C;
        alu_op(3'd6);
        in_valid = 1'b0;
        chk("inp_cap_ac",  32'(ac),  32'h125A);
        chk("inp_cap_fgi", 32'(fgi), 32'h1);
        alu_op(3'd6);
        chk("inp2_ac", 32'(ac), 32'h123C);

        // Output channel.
        set_ac(16'h00C3);
        outr_ld = 1'b1; step();
        chk("out_data",  32'(out_data),  32'hC3);
        chk("out_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b0; step(); step();
        chk("out_stall", 32'(out_valid), 32'h1);
        out_ready = 1'b1; step();
        out_ready = 1'b0;
        chk("out_fgo", 32'(fgo), 32'h1);
        set_ac(16'h0044);
        outr_ld = 1'b1; step();
        set_ac(16'h0055);
        outr_ld = 1'b1; out_ready = 1'b1; step();
        chk("ld_wins_data", 32'(out_data), 32'h55);
        chk("ld_wins_fgo",  32'(fgo),      32'h0);
        step();
        out_ready = 1'b0;
        chk("consume_fgo", 32'(fgo), 32'h1);

        // Interrupt enable.
        ien_set = 1'b1; step();
`ifdef MANO_DP_INT_EN
        chk("irq_on", 32'(irq), 32'h1);
        chk("ien_on", 32'(ien), 32'h1);
`else
        chk("irq_off", 32'(irq), 32'h0);
        chk("ien_off", 32'(ien), 32'h0);
`endif
        ien_set = 1'b1; ien_clr = 1'b1; step();
        chk("ien_clr_wins", 32'(ien), 32'h0);
        chk("irq_cleared",  32'(irq), 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
